lsu_byte_sequencer: RTL
=======================

// Module: lsu_byte_sequencer
// PURPOSE
//  Load/store sequencer between the core's MEM stage and a byte-wide synchronous data RAM.
//  Accepts one RISC-V load/store at a time and splits it into 1/2/4 single-byte RAM
//  accesses (little-endian). Assembles load data with sign/zero extension.
//  Flags misaligned, out-of-range and illegal-funct3 requests without touching memory.
// PARAMETERS
//  ADDR_W      32    width of the RAM byte address (mem_addr)
//  MEM_BYTES   4096  RAM size in bytes; any byte of the access at >= MEM_BYTES is an error
//  ALIGN_CHECK 1     1: LH/SH need addr[0]=0, LW/SW need addr[1:0]=0; 0: any alignment allowed
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  req_valid   in   1       core request present
//  req_ready   out  1       block can accept; request taken when req_valid&req_ready at edge
//  req_write   in   1       1=store, 0=load
//  req_funct3  in   3       LB/SB=000 LH/SH=001 LW/SW=010 LBU=100 LHU=101
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data, byte k goes to addr+k
//  resp_valid  out  1       one-cycle pulse: access complete (no backpressure)
//  resp_err    out  1       valid with resp_valid; 1 = rejected, no bytes accessed
//  resp_rdata  out  32      load result, extended; 0 for stores and errors
//  mem_addr    out  ADDR_W  RAM byte address
//  mem_re      out  1       RAM read strobe
//  mem_we      out  1       RAM write strobe
//  mem_wdata   out  8       RAM write byte
//  mem_rdata   in   8       RAM read byte, valid the cycle after mem_re is sampled
// BEHAVIOUR
//  States: IDLE, XFER, DRAIN, RESP. All outputs registered or decoded from state/regs.
//  Reset (async, reset=0): state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0;
//   mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0; byte counter and capture regs cleared.
//  Reset mid-store aborts: bytes already written stay written; the block never clears RAM.
//  IDLE: req_ready=1. On accept, latch write/funct3/addr/wdata, N = 1/2/4 from funct3[1:0].
//   Error if funct3 not legal for the direction (stores: only 000/001/010),
//   or misaligned (ALIGN_CHECK=1), or addr+N-1 >= MEM_BYTES (computed 33-bit, no wrap).
//   Error -> RESP with resp_err=1. Otherwise -> XFER with cnt=0.
//  XFER: cnt 0..N-1, one byte per cycle; mem_addr=addr+cnt (truncated to ADDR_W).
//   Store: mem_we=1, mem_wdata=wdata[8*cnt+7:8*cnt]. Load: mem_re=1.
//   Load: capture mem_rdata as byte cnt-1 when cnt>0.
//   At cnt=N-1: store -> RESP, load -> DRAIN.
//  DRAIN (loads only): mem_re=0; capture byte N-1; -> RESP.
//  RESP: resp_valid=1 for exactly one cycle; -> IDLE. req_ready=0 in XFER/DRAIN/RESP.
//  Load extension: LB sign bit 7, LH sign bit 15, LBU/LHU zero-extend, LW unchanged.
//  Latency after accept edge (cycle 0): store resp_valid in cycle N+1;
//   load in cycle N+2; error in cycle 1.
//  Next accept earliest in the cycle after RESP. No request is dropped.
//   A request held through a busy period is taken once IDLE is reached.
//  mem_re and mem_we are never high together. Both are 0 outside XFER.
// TESTING
//  1 SW 0x100 wdata 0xDEADBEEF -> mem_we cycles 1-4, addr 0x100..0x103, bytes EF,BE,AD,DE;
//    resp_valid cycle 5, err=0.
//  2 After 1: LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD;
//    LW 0x100 -> 0xDEADBEEF with resp_valid in cycle 6.
//  3 LH 0x101 (ALIGN_CHECK=1) -> resp_valid cycle 1, err=1, rdata=0, no mem_re;
//    SW with funct3=100 -> err=1, no mem_we.
//  4 LW at MEM_BYTES-2 -> err=1, no RAM access; LB at MEM_BYTES-1 -> err=0.
//    With ALIGN_CHECK=0: LW 0x101 -> bytes 0x101..0x104, no error.
//  5 Reset low in cycle 2 of an SW -> mem_we=0 and resp_valid=0 immediately.
//    Only byte 0 written. After release: req_ready=1 and a new LW completes normally.
//  6 req_valid held high with two requests back-to-back -> req_ready=0 until after RESP.
//    Second request accepted the cycle after the first resp_valid. Both responses correct.

Source files
------------

// File: rtl/lsu_byte_sequencer_if.sv
// Core-side request/response and byte-RAM bus of the LSU byte sequencer.
// The slave modport is the sequencer's view; master is the core+RAM side.
interface lsu_byte_sequencer_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Splits one RISC-V load/store into little-endian single-byte RAM accesses and
// assembles sign/zero-extended load data; bad requests are rejected without RAM access.
module lsu_byte_sequencer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_BYTES   = 4096,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  lsu_byte_sequencer_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StXfer  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic        err_q, err_d;

  // Request decode, evaluated on the incoming request while idle.
  logic [1:0]  req_last;
  logic        req_legal, req_misaligned, req_oor, req_err;
  logic [32:0] req_end;

  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
    if (bus.req_write) begin
      req_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      req_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    req_misaligned = 1'b0;
    if (ALIGN_CHECK) begin
      req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end
    // 33-bit end address so a request near 2^32 cannot wrap into range.
    req_end = {1'b0, bus.req_addr} + {31'b0, req_last};
    req_oor = req_end >= 33'(MEM_BYTES);
    req_err = !req_legal || req_misaligned || req_oor;
  end

  // Read data returns one cycle after the strobe, so byte cnt-1 lands during byte cnt.
  logic       cap_en;
  logic [1:0] cap_idx;

  always_comb begin
    cap_en  = !write_q && (((state_q == StXfer) && (cnt_q != 2'd0)) || (state_q == StDrain));
    cap_idx = (state_q == StDrain) ? last_q : cnt_q - 2'd1;
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    err_d    = err_q;

    for (int k = 0; k < 4; k++) begin
      if (cap_en && (cap_idx == 2'(k))) begin
        rdata_d[8*k +: 8] = bus.mem_rdata;
      end
    end

    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          cnt_d    = 2'd0;
          last_d   = req_last;
          err_d    = req_err;
          state_d  = req_err ? StResp : StXfer;
        end
      end
      StXfer: begin
        if (cnt_q == last_q) begin
          state_d = write_q ? StResp : StDrain;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StDrain: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= 2'd0;
      last_q   <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  logic        in_xfer;
  logic [31:0] xfer_addr;
  logic [7:0]  store_byte;
  logic [31:0] load_ext;

  always_comb begin
    in_xfer   = (state_q == StXfer);
    xfer_addr = addr_q + {30'b0, cnt_q};
    case (cnt_q)
      2'd0:    store_byte = wdata_q[7:0];
      2'd1:    store_byte = wdata_q[15:8];
      2'd2:    store_byte = wdata_q[23:16];
      default: store_byte = wdata_q[31:24];
    endcase
    case (funct3_q)
      3'b000:  load_ext = {{24{rdata_q[7]}}, rdata_q[7:0]};
      3'b001:  load_ext = {{16{rdata_q[15]}}, rdata_q[15:0]};
      3'b100:  load_ext = {24'b0, rdata_q[7:0]};
      3'b101:  load_ext = {16'b0, rdata_q[15:0]};
      default: load_ext = rdata_q;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.resp_valid = (state_q == StResp);
    bus.resp_err   = (state_q == StResp) && err_q;
    bus.resp_rdata = ((state_q == StResp) && !err_q && !write_q) ? load_ext : '0;
    bus.mem_re     = in_xfer && !write_q;
    bus.mem_we     = in_xfer && write_q;
    bus.mem_addr   = in_xfer ? ADDR_W'(xfer_addr) : '0;
    bus.mem_wdata  = (in_xfer && write_q) ? store_byte : 8'h00;
  end

endmodule
